// File: rtl/mac_dot_engine.sv
// Multiply-accumulate dot-product engine over two coefficient banks, valid/ready result port.
// Define MAC_SAT_EN for saturating adds with a sticky overflow flag; otherwise adds wrap.
module mac_dot_engine #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned ACC_W  = 20,
   parameter int unsigned SIGNED = 0
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              wr_en_i,
   input  logic              wr_sel_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              start_i,
   input  logic [ADDR_W:0]   len_i,
   output logic              busy_o,
   output logic              res_valid_o,
   input  logic              res_ready_i,
   output logic [ACC_W-1:0]  res_data_o,
   output logic              overflow_o
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   localparam logic [ADDR_W:0] DepthLen = (ADDR_W+1)'(DEPTH);
   localparam logic            SignedOp = (SIGNED != 0);

   logic [DATA_W-1:0] mem_a [DEPTH];
   logic [DATA_W-1:0] mem_b [DEPTH];

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
   logic                pv_q, pv_d;
   logic [ACC_W-1:0]    acc_q, acc_d, res_q, res_d;
   logic                ovf_q, ovf_d;

   logic [2*DATA_W-1:0] a_x, b_x, prod;
   logic [ACC_W-1:0]    prod_x, add_res;
   logic                add_ovf;

   // Banks are unreset and always writable; reads see pre-write data.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         if (wr_sel_i) mem_b[wr_addr_i] <= wr_data_i;
         else          mem_a[wr_addr_i] <= wr_data_i;
      end
   end

   assign a_x    = {{DATA_W{SignedOp & a_q[DATA_W-1]}}, a_q};
   assign b_x    = {{DATA_W{SignedOp & b_q[DATA_W-1]}}, b_q};
   assign prod   = a_x * b_x;
   assign prod_x = SignedOp ? ACC_W'($signed(prod)) : ACC_W'(prod);

`ifdef MAC_SAT_EN
   logic [ACC_W:0] sum;
   assign sum = {SignedOp & acc_q[ACC_W-1], acc_q} + {SignedOp & prod_x[ACC_W-1], prod_x};

   always_comb begin
      add_ovf = SignedOp ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
      add_res = sum[ACC_W-1:0];
      if (add_ovf) begin
         // Signed clamp direction follows the true sign held in the extra bit.
         add_res = SignedOp ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : '1;
      end
   end
`else
   assign add_res = acc_q + prod_x;
   assign add_ovf = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      a_d     = a_q;
      b_d     = b_q;
      pv_d    = pv_q;
      acc_d   = acc_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               len_d = (len_i > DepthLen) ? DepthLen : len_i;
               acc_d = '0;
               ovf_d = 1'b0;
               idx_d = '0;
               pv_d  = 1'b0;
               if (len_i == '0) begin
                  res_d   = '0;
                  state_d = StDone;
               end else begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            a_d   = mem_a[idx_q];
            b_d   = mem_b[idx_q];
            pv_d  = 1'b1;
            idx_d = idx_q + 1'b1;
            if (pv_q) begin
               acc_d = add_res;
               ovf_d = ovf_q | add_ovf;
            end
            if ({1'b0, idx_q} == len_q - 1'b1) state_d = StDrain;
         end
         StDrain: begin
            acc_d   = add_res;
            res_d   = add_res;
            ovf_d   = ovf_q | add_ovf;
            state_d = StDone;
         end
         StDone: begin
            if (res_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         idx_q   <= '0;
         len_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         pv_q    <= 1'b0;
         acc_q   <= '0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         a_q     <= a_d;
         b_q     <= b_d;
         pv_q    <= pv_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy_o      = (state_q != StIdle);
   assign res_valid_o = (state_q == StDone);
   assign res_data_o  = res_q;
   assign overflow_o  = ovf_q;

endmodule
